// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: issues word fetches to instruction memory, feeds the
// IF/OF pipeline register, absorbs one word in a skid buffer while operand
// fetch stalls, and flushes on execute-stage redirects.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    KILL  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic [31:0] buf_instr, buf_instr_nxt;
  logic [31:0] buf_pc, buf_pc_nxt;
  logic [31:0] instruction_nxt;
  logic [31:0] pc_nxt;
  logic        valid_nxt;

  logic [31:0] br_target;
  logic [31:0] seq_addr;

  assign br_target = branch_pc & ~32'd3;
  assign seq_addr  = req_addr + 32'd4;

  // Memory interface: the request address is always the registered req_addr.
  assign imem_addr = req_addr;
  assign imem_req  = !reset && (state != FULL);

  // State register and IF/OF pipeline register, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      req_addr    <= RESET_PC;
      buf_instr   <= '0;
      buf_pc      <= '0;
      instruction <= '0;
      pc          <= '0;
      valid       <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      req_addr    <= req_addr_nxt;
      buf_instr   <= buf_instr_nxt;
      buf_pc      <= buf_pc_nxt;
      instruction <= instruction_nxt;
      pc          <= pc_nxt;
      valid       <= valid_nxt;
    end
  end

  // Next-state logic: redirects first, then memory returns, then skid drain.
  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    req_addr_nxt    = req_addr;
    buf_instr_nxt   = buf_instr;
    buf_pc_nxt      = buf_pc;
    instruction_nxt = instruction;
    pc_nxt          = pc;
    valid_nxt       = valid;

    case (state)
      FETCH: begin
        if (branch_taken) begin
          valid_nxt     = 1'b0;
          buf_instr_nxt = '0;
          buf_pc_nxt    = '0;
          fetch_pc_nxt  = br_target;
          if (imem_ready) begin
            req_addr_nxt = br_target;
            state_nxt    = FETCH;
          end else begin
            // Request still in flight: keep the address stable and drop
            // the eventual response in KILL.
            state_nxt = KILL;
          end
        end else if (imem_ready) begin
          fetch_pc_nxt = seq_addr;
          req_addr_nxt = seq_addr;
          if (stall) begin
            buf_instr_nxt = imem_rdata;
            buf_pc_nxt    = req_addr;
            state_nxt     = FULL;
          end else begin
            instruction_nxt = imem_rdata;
            pc_nxt          = req_addr;
            valid_nxt       = 1'b1;
          end
        end else if (!stall) begin
          valid_nxt = 1'b0;
        end
      end

      FULL: begin
        if (branch_taken) begin
          valid_nxt     = 1'b0;
          buf_instr_nxt = '0;
          buf_pc_nxt    = '0;
          fetch_pc_nxt  = br_target;
          req_addr_nxt  = br_target;
          state_nxt     = FETCH;
        end else if (!stall) begin
          instruction_nxt = buf_instr;
          pc_nxt          = buf_pc;
          valid_nxt       = 1'b1;
          state_nxt       = FETCH;
        end
      end

      KILL: begin
        valid_nxt = 1'b0;
        if (branch_taken) begin
          fetch_pc_nxt = br_target;
        end
        if (imem_ready) begin
          // A redirect arriving on the same cycle as the stale response
          // wins over the previously latched target.
          req_addr_nxt = branch_taken ? br_target : fetch_pc;
          state_nxt    = FETCH;
        end
      end

      default: begin
        state_nxt = FETCH;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        valid;

  // Second instance exercising address wrap-around from a high reset PC.
  logic        w_reset;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_pc(branch_pc),
    .instruction(instruction), .pc(pc), .valid(valid)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .reset(w_reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rdata(w_rdata), .stall(1'b0),
    .branch_taken(1'b0), .branch_pc(32'h0),
    .instruction(w_instr), .pc(w_pc), .valid(w_valid)
  );

  // Reference model: a stream of words at increasing addresses, an optional
  // one-entry holding queue, and a "drop next response" flag after redirects.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_buf[$];
  logic [31:0] m_addr;
  logic [31:0] m_fetch;
  logic        m_discard;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;

  function automatic logic exp_req();
    return !reset && (m_buf.size() == 0);
  endfunction

  task automatic model_reset();
    m_buf.delete();
    m_addr    = 32'h0;
    m_fetch   = 32'h0;
    m_discard = 1'b0;
    m_instr   = 32'h0;
    m_pc      = 32'h0;
    m_valid   = 1'b0;
  endtask

  task automatic model_step();
    logic        req;
    logic [31:0] tgt;
    ent_t        e;
    if (reset) begin
      model_reset();
      return;
    end
    req = (m_buf.size() == 0);
    tgt = branch_pc & ~32'd3;
    if (branch_taken) begin
      m_valid = 1'b0;
      m_buf.delete();
      m_fetch = tgt;
      if (req && !imem_ready) begin
        m_discard = 1'b1;
      end else begin
        m_addr    = tgt;
        m_discard = 1'b0;
      end
    end else if (req && imem_ready) begin
      if (m_discard) begin
        m_addr    = m_fetch;
        m_discard = 1'b0;
      end else if (stall) begin
        e.instr = mem_word(m_addr);
        e.pc    = m_addr;
        m_buf.push_back(e);
        m_addr  = m_addr + 32'd4;
        m_fetch = m_addr;
      end else begin
        m_instr = mem_word(m_addr);
        m_pc    = m_addr;
        m_valid = 1'b1;
        m_addr  = m_addr + 32'd4;
        m_fetch = m_addr;
      end
    end else if (!req) begin
      if (!stall) begin
        e       = m_buf.pop_front();
        m_instr = e.instr;
        m_pc    = e.pc;
        m_valid = 1'b1;
      end
    end else if (!m_discard && !stall) begin
      m_valid = 1'b0;
    end
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance the model,
  // and return at the next falling edge.
  task automatic apply(input logic r, input logic s, input logic b, input logic [31:0] bp);
    imem_ready   = r;
    stall        = s;
    branch_taken = b;
    branch_pc    = bp;
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      n_checks++;
      if (imem_req !== 1'b0) begin
        n_fail++; $display("FAIL reset_req: got %b want 0", imem_req);
      end
    end
    n_checks++;
    if (valid !== 1'b0 || pc !== 32'h0 || instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got valid=%b pc=%h instr=%h want 0/0/0", valid, pc, instruction);
    end
  endtask

  task automatic test_sequential();
    reset = 1'b1;
    apply(1'b1, 1'b0, 1'b1, 32'h40);
    apply(1'b1, 1'b1, 1'b1, 32'h80);
    reset = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL seq_first_req: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (valid !== 1'b1 || pc !== 32'(4 * k) || instruction !== mem_word(32'(4 * k))) begin
        n_fail++;
        $display("FAIL seq_pc%0d: got valid=%b pc=%h instr=%h want 1/%h/%h",
                 k, valid, pc, instruction, 32'(4 * k), mem_word(32'(4 * k)));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] p;
    p = m_pc;
    apply(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (imem_req !== 1'b0 || valid !== 1'b1 || pc !== p) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got req=%b valid=%b pc=%h want 0/1/%h", i, imem_req, valid, pc, p);
      end
      if (i < 2) apply(1'b1, 1'b1, 1'b0, 32'h0);
    end
    apply(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (valid !== 1'b1 || pc !== p + 32'd4 || instruction !== mem_word(p + 32'd4)
        || imem_req !== 1'b1 || imem_addr !== p + 32'd8) begin
      n_fail++;
      $display("FAIL stall_release: got valid=%b pc=%h addr=%h want 1/%h/%h",
               valid, pc, imem_addr, p + 32'd4, p + 32'd8);
    end
    apply(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (valid !== 1'b1 || pc !== p + 32'd8 || instruction !== mem_word(p + 32'd8)) begin
      n_fail++;
      $display("FAIL stall_next: got valid=%b pc=%h want 1/%h", valid, pc, p + 32'd8);
    end
  endtask

  task automatic test_branch_fetch();
    apply(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    n_checks++;
    if (valid !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL brf_flush: got valid=%b req=%b addr=%h want 0/1/00000100", valid, imem_req, imem_addr);
    end
    apply(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (valid !== 1'b1 || pc !== 32'h100 || instruction !== mem_word(32'h100)) begin
      n_fail++;
      $display("FAIL brf_target: got valid=%b pc=%h want 1/00000100", valid, pc);
    end
  endtask

  task automatic test_branch_wait();
    logic [31:0] a;
    a = m_addr;
    apply(1'b0, 1'b0, 1'b1, 32'h0000_0203);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== a || valid !== 1'b0) begin
        n_fail++;
        $display("FAIL brw_hold%0d: got req=%b addr=%h valid=%b want 1/%h/0", i, imem_req, imem_addr, valid, a);
      end
      if (i < 3) apply(1'b0, 1'b0, 1'b0, 32'h0);
    end
    apply(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (valid !== 1'b0 || imem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL brw_discard: got valid=%b addr=%h want 0/00000200", valid, imem_addr);
    end
    apply(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (valid !== 1'b1 || pc !== 32'h200 || instruction !== mem_word(32'h200)) begin
      n_fail++;
      $display("FAIL brw_target: got valid=%b pc=%h want 1/00000200", valid, pc);
    end
  endtask

  task automatic test_branch_full();
    apply(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL brfull_enter: got req=%b want 0", imem_req);
    end
    apply(1'b0, 1'b1, 1'b1, 32'h0000_0300);
    n_checks++;
    if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      n_fail++;
      $display("FAIL brfull_flush: got valid=%b req=%b addr=%h want 0/1/00000300", valid, imem_req, imem_addr);
    end
    apply(1'b1, 1'b1, 1'b0, 32'h0);
    apply(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (valid !== 1'b1 || pc !== 32'h300 || instruction !== mem_word(32'h300)) begin
      n_fail++;
      $display("FAIL brfull_target: got valid=%b pc=%h want 1/00000300", valid, pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    w_reset = 1'b0;
    #1;
    n_checks++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFF8) begin
      n_fail++; $display("FAIL wrap_first_req: got req=%b addr=%h want 1/fffffff8", w_req, w_addr);
    end
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (w_valid !== 1'b1 || w_pc !== exp_pc[k] || w_instr !== mem_word(exp_pc[k])) begin
        n_fail++;
        $display("FAIL wrap_pc%0d: got valid=%b pc=%h want 1/%h", k, w_valid, w_pc, exp_pc[k]);
      end
    end
  endtask

  task automatic test_random();
    logic        r, s, b;
    logic [31:0] bp;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_checks++;
      if (imem_req !== exp_req()) begin
        n_fail++; $display("FAIL rand_req cyc %0d: got %b want %b", cyc, imem_req, exp_req());
      end
      if (!reset) begin
        n_checks++;
        if (imem_addr !== m_addr) begin
          n_fail++; $display("FAIL rand_addr cyc %0d: got %h want %h", cyc, imem_addr, m_addr);
        end
      end
      n_checks++;
      if (valid !== m_valid) begin
        n_fail++; $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, valid, m_valid);
      end
      if (m_valid) begin
        n_checks++;
        if (pc !== m_pc || instruction !== m_instr) begin
          n_fail++;
          $display("FAIL rand_out cyc %0d: got pc=%h instr=%h want %h/%h", cyc, pc, instruction, m_pc, m_instr);
        end
      end
      reset = ($urandom_range(0, 299) == 0);
      r = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 15) == 0);
      bp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      apply(r, s, b, bp);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    w_reset      = 1'b1;
    imem_ready   = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_pc    = 32'h0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_branch_fetch();
    test_branch_wait();
    test_branch_full();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory request valid.
REQ-005 imem_addr  output  32  instruction-memory word address (byte address, bits [1:0]=0).
REQ-006 imem_ready  input  1  imem_rdata valid this cycle for the current imem_addr.
REQ-007 imem_rdata  input  32  instruction word returned by memory.
REQ-008 stall  input  1  operand-fetch stage cannot accept a new instruction this cycle.
REQ-009 branch_taken  input  1  execute-stage redirect request.
REQ-010 branch_pc  input  32  redirect target, valid when branch_taken=1.
REQ-011 instruction  output  32  IF/OF pipeline register: instruction word to operand fetch.
REQ-012 pc  output  32  IF/OF pipeline register: address of instruction.
REQ-013 valid  output  1  instruction/pc hold a live instruction.

Function
REQ-014 Internal state: fetch_pc (next address to fetch), req_addr (address presented on imem_addr), skid buffer (buf_instr, buf_pc), FSM state in {FETCH, FULL, KILL}.
REQ-015 imem_addr SHALL equal req_addr at all times; imem_req SHALL be 1 in FETCH and KILL, 0 in FULL and while reset=1.
REQ-016 req_addr SHALL remain stable while imem_req=1 and imem_ready=0, including across branch_taken.
REQ-017 FETCH, imem_ready=1, stall=0, branch_taken=0: instruction<=imem_rdata, pc<=req_addr, valid<=1, fetch_pc and req_addr <= req_addr+4, stay FETCH.
REQ-018 FETCH, imem_ready=1, stall=1, branch_taken=0: buf_instr<=imem_rdata, buf_pc<=req_addr, fetch_pc and req_addr <= req_addr+4, IF/OF register unchanged, go FULL.
REQ-019 FETCH, imem_ready=0, branch_taken=0: stall=1 holds IF/OF register; stall=0 sets valid<=0 (bubble), instruction/pc unchanged.
REQ-020 FULL, stall=1, branch_taken=0: all state held, no request issued.
REQ-021 FULL, stall=0, branch_taken=0: instruction<=buf_instr, pc<=buf_pc, valid<=1, go FETCH.
REQ-022 branch_taken=1 SHALL take priority over every other event in every state: valid<=0, skid buffer discarded, fetch_pc<=branch_pc; stall is ignored for the flush.
REQ-023 branch_taken=1 with no outstanding request (FULL, or FETCH with imem_ready=1): req_addr<=branch_pc, go FETCH; returned data discarded.
REQ-024 branch_taken=1 in FETCH with imem_ready=0: req_addr unchanged, go KILL.
REQ-025 KILL: imem_req=1 on old req_addr; on imem_ready=1, discard imem_rdata, req_addr<=fetch_pc, go FETCH; valid stays 0.
REQ-026 branch_taken=1 in KILL: fetch_pc<=branch_pc (latest target wins), remain KILL until imem_ready=1.
REQ-027 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 without error.
REQ-028 branch_pc bits [1:0] SHALL be forced to 0 when loaded.
REQ-029 No instruction SHALL be duplicated or dropped except those flushed by branch_taken; order equals fetch order.
REQ-030 Latency: memory data returned with imem_ready=1 in cycle N appears on instruction/valid at edge N+1 when stall=0.

Reset
REQ-031 reset=1 at a clock edge SHALL set state=FETCH, fetch_pc=req_addr=RESET_PC, valid=0, instruction=32'h0, pc=32'h0, skid buffer cleared, overriding stall and branch_taken.
REQ-032 reset mid-request SHALL abandon it; any imem_ready during reset is ignored; first request after reset is to RESET_PC.

Verification
REQ-033 Reset, imem_ready=1 every cycle, stall=0 -> pc sequence 0,4,8,12 with valid=1 from second cycle after reset release, instruction equals memory word.
REQ-034 Stall asserted 3 cycles while memory ready -> one word captured to buffer, imem_req=0 for stall duration, on release pc continues contiguously, no duplicate or gap.
REQ-035 branch_taken=1, branch_pc=32'h0000_0100 in FETCH with imem_ready=1 -> valid=0 next cycle, next fetch address 0x100, next valid pc=0x100.
REQ-036 branch_taken=1, branch_pc=0x200 while imem_ready=0 for 4 cycles -> imem_addr held at old address, returned word discarded, next imem_addr=0x200.
REQ-037 branch_taken=1 in FULL with stall=1 -> buffer discarded, valid=0, next fetch at branch_pc.
REQ-038 RESET_PC=32'hFFFF_FFF8, continuous ready -> pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
